// File: rtl/temp_buf_ctrl_pkg.sv
// Shared types for the temp_buffer command sequencer: pixel width, packet layout,
// write modes and the sequencer FSM state encoding.
package temp_buf_ctrl_pkg;

    localparam int unsigned CNN_XLEN = 16;

    typedef enum logic [1:0] {
        NO_WR   = 2'd0,
        WR_DATA = 2'd1,
        WR_BUF  = 2'd2
    } TEMP_BUF_WR_MODE;

    typedef struct packed {
        logic                       clean;
        TEMP_BUF_WR_MODE            wr_r;
        TEMP_BUF_WR_MODE            wr_c;
        logic                       rd_r;
        logic                       rd_c;
        logic signed [CNN_XLEN-1:0] data_wr;
        logic                       stride;
    } TEMP_BUF_PACKET;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAN,
        ST_LOAD,
        ST_ROW_RD,
        ST_COL_RD
    } TEMP_BUF_CTRL_STATE;

    function automatic TEMP_BUF_PACKET idle_packet(input logic stride);
        TEMP_BUF_PACKET p;
        p        = '0;
        p.wr_r   = NO_WR;
        p.wr_c   = NO_WR;
        p.stride = stride;
        return p;
    endfunction

endpackage

// File: rtl/temp_buf_ctrl_counter.sv
// tbc_counter: loadable down-counter with a zero flag; clr has priority over load,
// load over dec, and dec saturates at zero.
module tbc_counter
    import temp_buf_ctrl_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/temp_buf_ctrl.sv
// temp_buf_ctrl: sequences clean / load / row-read / column-read packets for temp_buffer.
// Optional protocol checking is enabled with `define TEMP_BUF_CTRL_CHK_EN.
module temp_buf_ctrl
    import temp_buf_ctrl_pkg::*;
#(
    parameter int unsigned KSIZE    = 3,
    parameter int unsigned ROW_LEN  = 8,
    parameter int unsigned NUM_ROWS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stride,
    input  logic                       abort,
    input  logic                       in_valid,
    input  logic signed [CNN_XLEN-1:0] in_data,
    output logic                       in_ready,
    output TEMP_BUF_PACKET             temp_pk,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned BEAT_W  = $clog2(ROW_LEN) + 1;
    localparam int unsigned PHASE_W = $clog2(ROW_LEN) + 1;
    localparam int unsigned ROW_W   = $clog2(NUM_ROWS) + 1;

    TEMP_BUF_CTRL_STATE state, next_state;
    TEMP_BUF_PACKET     cmd;

    logic               stride_q;
    logic               kill;
    logic               accept;
    logic               start_acc;
    logic               done_d;
    logic               beat_load, beat_dec, beat_zero;
    logic               phase_load, phase_dec, phase_zero;
    logic               row_load, row_dec, row_zero;
    logic [PHASE_W-1:0] phase_val;
    logic [PHASE_W-1:0] col_last;

    assign kill     = abort && (state != ST_IDLE);
    assign in_ready = (state == ST_LOAD);
    assign accept   = in_ready && in_valid;
    assign col_last = stride_q ? PHASE_W'(ROW_LEN / 2 - 1) : PHASE_W'(ROW_LEN - 1);

    // Counters hold "remaining minus one", so zero marks the final beat/cycle/row.
    tbc_counter #(.W(BEAT_W)) u_beat_cnt (
        .clk      (clk),
        .rst      (reset),
        .clr      (kill),
        .load     (beat_load),
        .load_val (BEAT_W'(ROW_LEN - 1)),
        .dec      (beat_dec),
        .zero     (beat_zero)
    );

    tbc_counter #(.W(PHASE_W)) u_phase_cnt (
        .clk      (clk),
        .rst      (reset),
        .clr      (kill),
        .load     (phase_load),
        .load_val (phase_val),
        .dec      (phase_dec),
        .zero     (phase_zero)
    );

    tbc_counter #(.W(ROW_W)) u_row_cnt (
        .clk      (clk),
        .rst      (reset),
        .clr      (kill),
        .load     (row_load),
        .load_val (ROW_W'(NUM_ROWS - 1)),
        .dec      (row_dec),
        .zero     (row_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (kill) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start && !abort) next_state = ST_CLEAN;
                ST_CLEAN:  next_state = ST_LOAD;
                ST_LOAD:   if (accept && beat_zero) next_state = ST_ROW_RD;
                ST_ROW_RD: if (phase_zero) next_state = ST_COL_RD;
                ST_COL_RD: if (phase_zero) next_state = row_zero ? ST_IDLE : ST_LOAD;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd        = idle_packet(stride_q);
        start_acc  = 1'b0;
        done_d     = 1'b0;
        beat_load  = 1'b0;
        beat_dec   = 1'b0;
        phase_load = 1'b0;
        phase_dec  = 1'b0;
        phase_val  = '0;
        row_load   = 1'b0;
        row_dec    = 1'b0;
        if (kill) begin
            cmd = idle_packet(1'b0);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        start_acc = 1'b1;
                        row_load  = 1'b1;
                    end
                end
                ST_CLEAN: begin
                    cmd.clean = 1'b1;
                    beat_load = 1'b1;
                end
                ST_LOAD: begin
                    if (accept) begin
                        cmd.wr_r    = WR_DATA;
                        cmd.wr_c    = WR_DATA;
                        cmd.data_wr = in_data;
                        if (beat_zero) begin
                            phase_load = 1'b1;
                            phase_val  = PHASE_W'(KSIZE - 1);
                        end else begin
                            beat_dec = 1'b1;
                        end
                    end
                end
                ST_ROW_RD: begin
                    cmd.rd_r = 1'b1;
                    if (phase_zero) begin
                        phase_load = 1'b1;
                        phase_val  = col_last;
                    end else begin
                        phase_dec = 1'b1;
                    end
                end
                ST_COL_RD: begin
                    cmd.rd_c = 1'b1;
                    cmd.wr_c = WR_BUF;
                    if (phase_zero) begin
                        if (row_zero) begin
                            done_d = 1'b1;
                        end else begin
                            row_dec   = 1'b1;
                            beat_load = 1'b1;
                        end
                    end else begin
                        phase_dec = 1'b1;
                    end
                end
                default: cmd = idle_packet(stride_q);
            endcase
        end
    end

    // Outputs are registered from the current state's command, so they trail the FSM by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            temp_pk  <= idle_packet(1'b0);
            busy     <= 1'b0;
            done     <= 1'b0;
            stride_q <= 1'b0;
        end else begin
            temp_pk <= cmd;
            busy    <= (state != ST_IDLE) && !kill;
            done    <= done_d;
            if (kill) begin
                stride_q <= 1'b0;
            end else if (start_acc) begin
                stride_q <= stride;
            end
        end
    end

`ifdef TEMP_BUF_CTRL_CHK_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((state != ST_IDLE) && (start || (in_valid && !in_ready))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_temp_buf_ctrl.sv
// Self-checking bench for temp_buf_ctrl: expected packet streams are built as tile-level
// sequences (clean, writes with stalls, row reads, column reads) and compared per cycle.
module tb_temp_buf_ctrl;
    import temp_buf_ctrl_pkg::*;

    localparam int KS = 3;
    localparam int RL = 8;
    localparam int NR = 2;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       start;
    logic                       stride;
    logic                       abort;
    logic                       in_valid;
    logic signed [CNN_XLEN-1:0] in_data;
    logic                       in_ready;
    TEMP_BUF_PACKET             temp_pk;
    logic                       busy;
    logic                       done;
    logic                       err;

    int total = 0;
    int bad   = 0;

    TEMP_BUF_PACKET             exp_pk[$];
    logic                       exp_vld[$];
    logic                       exp_rdy[$];
    logic signed [CNN_XLEN-1:0] exp_dat[$];
    TEMP_BUF_PACKET             obs_pk[$];
    logic                       obs_busy[$];
    logic                       obs_done[$];
    logic                       obs_rdy[$];
    logic                       obs_err[$];
    logic signed [CNN_XLEN-1:0] pix[$];
    int                         stall[$];

    always #5 clk = ~clk;

    temp_buf_ctrl #(.KSIZE(KS), .ROW_LEN(RL), .NUM_ROWS(NR)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stride   (stride),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .temp_pk  (temp_pk),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    function automatic TEMP_BUF_PACKET mk(input logic s);
        TEMP_BUF_PACKET p;
        p        = '0;
        p.stride = s;
        return p;
    endfunction

    task automatic push(input TEMP_BUF_PACKET p, input logic v, input logic r,
                        input logic signed [CNN_XLEN-1:0] d);
        exp_pk.push_back(p);
        exp_vld.push_back(v);
        exp_rdy.push_back(r);
        exp_dat.push_back(d);
    endtask

    task automatic set_pixels(input bit seq, input bit rand_stall);
        pix.delete();
        stall.delete();
        for (int i = 0; i < RL * NR; i++) begin
            pix.push_back(seq ? CNN_XLEN'(i + 1) : CNN_XLEN'($urandom));
            stall.push_back((rand_stall && ($urandom_range(0, 3) == 0)) ? int'($urandom_range(1, 2)) : 0);
        end
    endtask

    // Expected output stream for one tile, one entry per output cycle starting at cycle 1.
    task automatic build_model(input logic s);
        TEMP_BUF_PACKET p;
        exp_pk.delete();
        exp_vld.delete();
        exp_rdy.delete();
        exp_dat.delete();
        p = mk(s);
        p.clean = 1'b1;
        push(p, 1'b0, 1'b0, '0);
        for (int r = 0; r < NR; r++) begin
            for (int b = 0; b < RL; b++) begin
                for (int st = 0; st < stall[r * RL + b]; st++) push(mk(s), 1'b0, 1'b1, '0);
                p = mk(s);
                p.wr_r = WR_DATA;
                p.wr_c = WR_DATA;
                p.data_wr = pix[r * RL + b];
                push(p, 1'b1, 1'b1, pix[r * RL + b]);
            end
            for (int i = 0; i < KS; i++) begin
                p = mk(s);
                p.rd_r = 1'b1;
                push(p, 1'b0, 1'b0, '0);
            end
            for (int i = 0; i < (s ? RL / 2 : RL); i++) begin
                p = mk(s);
                p.rd_c = 1'b1;
                p.wr_c = WR_BUF;
                push(p, 1'b0, 1'b0, '0);
            end
        end
    endtask

    // Called at a negedge; start is sampled by the next posedge, then n output cycles are recorded.
    task automatic run_tile(input logic s, input int n, input int abort_at, input int glitch_at);
        obs_pk.delete();
        obs_busy.delete();
        obs_done.delete();
        obs_rdy.delete();
        obs_err.delete();
        start = 1'b1;
        stride = s;
        in_valid = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (k <= exp_vld.size() && exp_vld[k-1]) begin
                in_valid = 1'b1;
                in_data = exp_dat[k-1];
            end else begin
                in_valid = 1'b0;
                in_data = CNN_XLEN'($urandom);
            end
            abort = (k == abort_at);
            start = (k == glitch_at);
            obs_rdy.push_back(in_ready);
            @(posedge clk);
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            in_valid = 1'b0;
            obs_pk.push_back(temp_pk);
            obs_busy.push_back(busy);
            obs_done.push_back(done);
            obs_err.push_back(err);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        stride = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (temp_pk !== mk(1'b0)) begin bad++; $display("FAIL reset_pk got %h exp %h", temp_pk, mk(1'b0)); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b exp 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b exp 0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got %b exp 0", err); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        TEMP_BUF_PACKET e;
        set_pixels(1'b1, 1'b0);
        build_model(1'b0);
        total++; if (exp_pk.size() != 39) begin bad++; $display("FAIL basic_len got %0d exp 39", exp_pk.size()); end
        run_tile(1'b0, exp_pk.size() + 2, 0, 0);
        for (int k = 0; k < obs_pk.size(); k++) begin
            e = (k < exp_pk.size()) ? exp_pk[k] : mk(1'b0);
            total++; if (obs_pk[k] !== e) begin bad++; $display("FAIL basic_pk cyc %0d got %h exp %h", k + 1, obs_pk[k], e); end
            total++; if ({obs_busy[k], obs_done[k], obs_rdy[k]} !== {k < exp_pk.size(), k == exp_pk.size() - 1, k < exp_rdy.size() && exp_rdy[k]})
                begin bad++; $display("FAIL basic_ctl cyc %0d got busy/done/rdy %b%b%b", k + 1, obs_busy[k], obs_done[k], obs_rdy[k]); end
        end
    endtask

    task automatic test_stride;
        TEMP_BUF_PACKET e;
        set_pixels(1'b0, 1'b0);
        build_model(1'b1);
        total++; if (exp_pk.size() != 31) begin bad++; $display("FAIL stride_len got %0d exp 31", exp_pk.size()); end
        run_tile(1'b1, exp_pk.size() + 2, 0, 0);
        for (int k = 0; k < obs_pk.size(); k++) begin
            e = (k < exp_pk.size()) ? exp_pk[k] : mk(1'b1);
            total++; if (obs_pk[k] !== e) begin bad++; $display("FAIL stride_pk cyc %0d got %h exp %h", k + 1, obs_pk[k], e); end
            total++; if ({obs_busy[k], obs_done[k], obs_rdy[k]} !== {k < exp_pk.size(), k == exp_pk.size() - 1, k < exp_rdy.size() && exp_rdy[k]})
                begin bad++; $display("FAIL stride_ctl cyc %0d got busy/done/rdy %b%b%b", k + 1, obs_busy[k], obs_done[k], obs_rdy[k]); end
        end
    endtask

    task automatic test_stall;
        TEMP_BUF_PACKET e;
        set_pixels(1'b1, 1'b0);
        stall[3] = 2;
        build_model(1'b0);
        total++; if (exp_pk.size() != 41) begin bad++; $display("FAIL stall_len got %0d exp 41", exp_pk.size()); end
        run_tile(1'b0, exp_pk.size() + 2, 0, 0);
        for (int k = 0; k < obs_pk.size(); k++) begin
            e = (k < exp_pk.size()) ? exp_pk[k] : mk(1'b0);
            total++; if (obs_pk[k] !== e) begin bad++; $display("FAIL stall_pk cyc %0d got %h exp %h", k + 1, obs_pk[k], e); end
            total++; if ({obs_busy[k], obs_done[k], obs_rdy[k]} !== {k < exp_pk.size(), k == exp_pk.size() - 1, k < exp_rdy.size() && exp_rdy[k]})
                begin bad++; $display("FAIL stall_ctl cyc %0d got busy/done/rdy %b%b%b", k + 1, obs_busy[k], obs_done[k], obs_rdy[k]); end
        end
    endtask

    task automatic test_abort;
        TEMP_BUF_PACKET e;
        set_pixels(1'b1, 1'b0);
        build_model(1'b1);
        run_tile(1'b1, 14, 11, 0);
        for (int k = 0; k < obs_pk.size(); k++) begin
            e = (k < 10) ? exp_pk[k] : mk(1'b0);
            total++; if (obs_pk[k] !== e) begin bad++; $display("FAIL abort_pk cyc %0d got %h exp %h", k + 1, obs_pk[k], e); end
            total++; if ({obs_busy[k], obs_done[k], obs_rdy[k]} !== {k < 10, 1'b0, k < 10 && exp_rdy[k]})
                begin bad++; $display("FAIL abort_ctl cyc %0d got busy/done/rdy %b%b%b", k + 1, obs_busy[k], obs_done[k], obs_rdy[k]); end
        end
        set_pixels(1'b0, 1'b0);
        build_model(1'b0);
        run_tile(1'b0, exp_pk.size() + 2, 0, 0);
        for (int k = 0; k < obs_pk.size(); k++) begin
            e = (k < exp_pk.size()) ? exp_pk[k] : mk(1'b0);
            total++; if (obs_pk[k] !== e) begin bad++; $display("FAIL post_abort_pk cyc %0d got %h exp %h", k + 1, obs_pk[k], e); end
            total++; if ({obs_busy[k], obs_done[k]} !== {k < exp_pk.size(), k == exp_pk.size() - 1})
                begin bad++; $display("FAIL post_abort_ctl cyc %0d got busy/done %b%b", k + 1, obs_busy[k], obs_done[k]); end
        end
    endtask

    task automatic test_back_to_back;
        TEMP_BUF_PACKET e;
        logic s;
        for (int t = 0; t < 3; t++) begin
            s = 1'($urandom_range(0, 1));
            set_pixels(1'b0, 1'b1);
            build_model(s);
            // Only the last tile idles afterwards; earlier ones hand straight over in the done cycle.
            run_tile(s, exp_pk.size() + ((t == 2) ? 2 : 0), 0, 0);
            for (int k = 0; k < obs_pk.size(); k++) begin
                e = (k < exp_pk.size()) ? exp_pk[k] : mk(s);
                total++; if (obs_pk[k] !== e) begin bad++; $display("FAIL b2b_pk tile %0d cyc %0d got %h exp %h", t, k + 1, obs_pk[k], e); end
                total++; if ({obs_busy[k], obs_done[k], obs_rdy[k]} !== {k < exp_pk.size(), k == exp_pk.size() - 1, k < exp_rdy.size() && exp_rdy[k]})
                    begin bad++; $display("FAIL b2b_ctl tile %0d cyc %0d got busy/done/rdy %b%b%b", t, k + 1, obs_busy[k], obs_done[k], obs_rdy[k]); end
            end
        end
    endtask

    task automatic test_err;
        TEMP_BUF_PACKET e;
        logic exp_err;
`ifdef TEMP_BUF_CTRL_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        set_pixels(1'b1, 1'b0);
        build_model(1'b0);
        run_tile(1'b0, exp_pk.size() + 2, 0, 5);
        for (int k = 0; k < obs_pk.size(); k++) begin
            e = (k < exp_pk.size()) ? exp_pk[k] : mk(1'b0);
            total++; if (obs_pk[k] !== e) begin bad++; $display("FAIL err_pk cyc %0d got %h exp %h", k + 1, obs_pk[k], e); end
            total++; if (obs_err[k] !== ((k >= 4) ? exp_err : 1'b0))
                begin bad++; $display("FAIL err_flag cyc %0d got %b exp %b", k + 1, obs_err[k], (k >= 4) ? exp_err : 1'b0); end
        end
    endtask

    task automatic test_async_reset;
        set_pixels(1'b1, 1'b0);
        build_model(1'b1);
        run_tile(1'b1, 4, 0, 0);
        total++; if ({in_ready, busy} !== 2'b11) begin bad++; $display("FAIL areset_pre got rdy/busy %b%b exp 11", in_ready, busy); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (temp_pk !== mk(1'b0)) begin bad++; $display("FAIL areset_pk got %h exp %h", temp_pk, mk(1'b0)); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL areset_in_ready got %b exp 0", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy got %b exp 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL areset_done got %b exp 0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL areset_err got %b exp 0", err); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if ({busy, done, in_ready} !== 3'b000) begin bad++; $display("FAIL areset_after got busy/done/rdy %b%b%b exp 000", busy, done, in_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stride();
        test_stall();
        test_abort();
        test_back_to_back();
        test_err();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/temp_buf_ctrl.md
# temp_buf_ctrl

Command sequencer directly upstream of `temp_buffer` in the CNN datapath. It accepts a pixel stream over a valid/ready handshake and emits one `TEMP_BUF_PACKET` per cycle in a fixed tile sequence:
- clean
- row/column writes
- row reads
- column reads with recirculation

It replaces hand-driven packet sequences and drives `temp_buffer.temp_pk` directly.

## Interface
Parameters:
- `KSIZE`, 3: kernel height; number of row-read cycles per row.
- `ROW_LEN`, 8: pixels per row; must be even and ≥ `KSIZE`.
- `NUM_ROWS`, 2: rows per tile.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin tile; sampled only in IDLE.
- `stride`  in  1  0 = stride 1, 1 = stride 2; latched on accepted `start`.
- `abort`  in  1  synchronous cancel; wins over `start`.
- `in_valid`  in  1  pixel valid.
- `in_data`  in  `CNN_XLEN`  signed pixel.
- `in_ready`  out  1  pixel accept.
- `temp_pk`  out  `TEMP_BUF_PACKET`  registered command to `temp_buffer`.
- `busy`  out  1  tile in progress.
- `done`  out  1  one-cycle tile-complete pulse.
- `err`  out  1  sticky protocol error (see Configuration).

## Operation
- FSM states and transitions:
  - IDLE → CLEAN on `start`.
  - CLEAN → LOAD after 1 cycle.
  - LOAD → ROW_RD after `ROW_LEN` accepted beats.
  - ROW_RD → COL_RD after `KSIZE` cycles.
  - COL_RD → LOAD if rows remain, else → IDLE.
- COL_RD lasts `ROW_LEN` cycles when `stride`=0 and `ROW_LEN/2` cycles when `stride`=1.
- Commands generated per FSM state:
  - IDLE: idle packet (`clean`=0, `wr_r`=`wr_c`=NO_WR, `rd_r`=`rd_c`=0, `data_wr`=0).
  - CLEAN: `clean`=1, otherwise idle.
  - LOAD, accepted beat: `wr_r`=`wr_c`=WR_DATA, `data_wr`=`in_data`.
  - LOAD, stall cycle: idle packet.
  - ROW_RD: `rd_r`=1.
  - COL_RD: `rd_c`=1, `wr_c`=WR_BUF.
- `temp_pk.stride` carries the latched stride in every packet and resets to 0.
- `in_ready` = FSM in LOAD and beat count < `ROW_LEN`; it is a function of state only, not of `in_valid`.
- A beat is accepted on a posedge where `in_valid`&`in_ready`.
- `start` while busy is ignored.
- `abort` sampled high in any non-IDLE state:
  - FSM → IDLE; counters and latched stride cleared.
  - Next `temp_pk` is the idle packet; pending command discarded.
  - `done` is not asserted.
- `abort` and `start` together in IDLE: stay IDLE.
- Counters are sized by `$clog2` of their maximum plus 1 bit; no wrap is possible within a tile.
- Reset values: FSM IDLE, `temp_pk` = idle packet with `stride`=0, `in_ready`=0, `busy`=0, `done`=0, `err`=0.
- `reset` asserted mid-tile returns everything to reset values immediately; no `done`.

## Timing
- `temp_pk` is the FSM command stream delayed by exactly one cycle.
- Cycle n means the n-th cycle after the posedge that samples `start`.
- No stalls, defaults, stride 0:
  - Cycle 1: clean.
  - Cycles 2–9: writes.
  - Cycles 10–12: `rd_r`.
  - Cycles 13–20: `rd_c`.
  - Cycles 21–39: row 2 (same pattern).
- `done` is high in the same cycle as the final `rd_c` packet (cycle 39).
- `busy` is high for cycles 1 through the `done` cycle inclusive.
- A new `start` is accepted on the posedge ending the `done` cycle.
- Each `in_valid`-low cycle in LOAD extends the tile by one cycle and inserts one idle packet.

## Configuration
- `TEMP_BUF_CTRL_CHK_EN` defined:
  - `err` sets on `start` while `busy`.
  - `err` also sets on `in_valid` high while `busy` and `in_ready` low.
  - Once set, `err` clears only on `reset`.
- `TEMP_BUF_CTRL_CHK_EN` undefined: `err` is tied 0; no check logic is generated.

## Structure
- Shared package holds:
  - `CNN_XLEN`.
  - The `TEMP_BUF_PACKET` struct.
  - The write-mode enum (NO_WR, WR_DATA, WR_BUF).
  - The new `TEMP_BUF_CTRL_STATE` enum.
- One sub-module, `tbc_counter`: loadable down-counter with a zero flag, instanced for beats, phase cycles and rows.

## Test plan
- Defaults, stride 0, `in_valid` held high, pixels 1..16:
  - Writes 1–8 on cycles 2–9, 9–16 on cycles 21–28.
  - 3 `rd_r` then 8 `rd_c`+WR_BUF per row.
  - `done` at cycle 39 only.
- Stride 1: 4 COL_RD cycles per row; `done` at cycle 31; `temp_pk.stride`=1 throughout.
- `in_valid` low for 2 cycles after the 3rd beat:
  - Exactly 2 idle packets inserted.
  - `data_wr` order preserved.
  - `done` at cycle 41.
- `abort` during the 2nd `rd_r` cycle:
  - Next packet is idle.
  - `busy`=0 next cycle; no `done`.
  - A subsequent `start` runs a full, clean tile.
- Async `reset` pulse mid-LOAD (between clocks): all outputs return to reset values immediately.
- With `TEMP_BUF_CTRL_CHK_EN`: `start` at cycle 5 sets `err`, which stays set; without the macro, `err` stays 0.
